// File: rtl/ts_sync_aligner.sv
// ts_sync_aligner: finds MPEG-2 TS packet boundaries from the 0x47 sync byte.
// It runs a HUNT -> VERIFY -> LOCKED flywheel and, while locked, writes the
// bytes of each admitted packet into a downstream async FIFO as
// {byte, valid, sync} words.
// Optional feature: define TS_ALIGN_DROP_CNT_EN to add the drop_cnt port and
// a saturating counter of suppressed or truncated packets.

module ts_sync_aligner #(
  parameter int unsigned PKT_LEN    = 188,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned LOSS_COUNT = 3
) (
  input  logic        wclk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        fifo_full,
  output logic        w_en,
  output logic [9:0]  data_out,
  output logic        locked
`ifdef TS_ALIGN_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int unsigned     PosW     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PosW-1:0] PosLast  = PosW'(PKT_LEN - 1);
  localparam logic [3:0]      LockCnt  = 4'(LOCK_COUNT);
  localparam logic [3:0]      LossCnt  = 4'(LOSS_COUNT);
  localparam logic [7:0]      SyncByte = 8'h47;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic [3:0]      good_q, good_d;
  logic [3:0]      miss_q, miss_d;
  logic            adm_q, adm_d;   // current packet admitted to the FIFO
  logic            w_en_q, w_en_d;
  logic [9:0]      data_q, data_d;

  logic [PosW-1:0] pos_inc;
  logic [3:0]      good_inc;
  logic [3:0]      miss_inc;
  logic            is_sync;
  logic            at_start;
  logic            start_pkt;      // byte at pos 0 opens a new packet in LOCKED
  logic            drop_evt;       // a packet got suppressed or truncated

  // Position arithmetic and sync detection shared by all states.
  always_comb begin
    pos_inc  = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
    good_inc = good_q + 4'd1;
    miss_inc = miss_q + 4'd1;
    is_sync  = (din == SyncByte);
    at_start = (pos_q == '0);
  end

  // Next-state logic: sync tracking, packet admission and FIFO word build.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    good_d    = good_q;
    miss_d    = miss_q;
    adm_d     = adm_q;
    w_en_d    = 1'b0;
    data_d    = data_q;
    start_pkt = 1'b0;
    drop_evt  = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (is_sync) begin
            pos_d  = pos_inc;
            good_d = 4'd1;
            if (LockCnt == 4'd1) begin
              // A single sync is enough: this byte already starts a packet.
              state_d   = StLocked;
              miss_d    = '0;
              start_pkt = 1'b1;
            end else begin
              state_d = StVerify;
            end
          end
        end

        StVerify: begin
          pos_d = pos_inc;
          if (at_start) begin
            if (is_sync) begin
              good_d = good_inc;
              if (good_inc == LockCnt) begin
                state_d   = StLocked;
                miss_d    = '0;
                start_pkt = 1'b1;
              end
            end else begin
              state_d = StHunt;
              pos_d   = '0;
              good_d  = '0;
            end
          end
        end

        StLocked: begin
          pos_d = pos_inc;
          if (at_start) begin
            if (is_sync) begin
              miss_d    = '0;
              start_pkt = 1'b1;
            end else if (miss_inc == LossCnt) begin
              // Lock lost: this byte and the rest of its packet are discarded.
              state_d = StHunt;
              pos_d   = '0;
              good_d  = '0;
              miss_d  = '0;
              adm_d   = 1'b0;
            end else begin
              // Flywheel: keep packet timing, emit the bad header with sync=0.
              miss_d    = miss_inc;
              start_pkt = 1'b1;
            end
          end else if (adm_q) begin
            if (fifo_full) begin
              adm_d    = 1'b0;
              drop_evt = 1'b1;
            end else begin
              w_en_d = 1'b1;
              data_d = {din, 1'b1, 1'b0};
            end
          end
        end

        default: begin
          state_d = StHunt;
          pos_d   = '0;
          good_d  = '0;
          miss_d  = '0;
          adm_d   = 1'b0;
        end
      endcase

      // Admission is decided once, on the packet-start byte.
      if (start_pkt) begin
        if (fifo_full) begin
          adm_d    = 1'b0;
          drop_evt = 1'b1;
        end else begin
          adm_d  = 1'b1;
          w_en_d = 1'b1;
          data_d = {din, 1'b1, is_sync};
        end
      end
    end
  end

  // State and output registers; one cycle from din to data_out/w_en.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_q <= StHunt;
      pos_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      adm_q   <= 1'b0;
      w_en_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      adm_q   <= adm_d;
      w_en_q  <= w_en_d;
      data_q  <= data_d;
    end
  end

  assign w_en     = w_en_q;
  assign data_out = data_q;
  assign locked   = (state_q == StLocked);

`ifdef TS_ALIGN_DROP_CNT_EN
  logic [15:0] drop_q;

  // Saturating count of packets lost to FIFO back-pressure while locked.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_evt && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
`endif

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Bench for ts_sync_aligner: random payload checked cycle by cycle against a
// behavioural packet model, plus directed scenario totals.
// Honours TS_ALIGN_DROP_CNT_EN when the design is built with it.

module tb_ts_sync_aligner;

  localparam int PKT   = 188;
  localparam int LOCKN = 3;
  localparam int LOSSN = 3;

  logic       wclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic       w_en;
  logic [9:0] data_out;
  logic       locked;
`ifdef TS_ALIGN_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  ts_sync_aligner #(
    .PKT_LEN   (PKT),
    .LOCK_COUNT(LOCKN),
    .LOSS_COUNT(LOSSN)
  ) dut (
    .wclk     (wclk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .fifo_full(fifo_full),
    .w_en     (w_en),
    .data_out (data_out),
    .locked   (locked)
`ifdef TS_ALIGN_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int failures = 0;

  // Reference model: 0 hunting, 1 verifying, 2 locked.
  int         m_st;
  int         m_pos;
  int         m_good;
  int         m_miss;
  int         m_drop;
  bit         m_adm;
  logic       exp_wen;
  logic [9:0] exp_data;

  logic [9:0] words[$];
  logic [9:0] q1[$];
  logic [7:0] stim[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_pos = 0; m_good = 0; m_miss = 0; m_drop = 0; m_adm = 1'b0;
    exp_wen = 1'b0; exp_data = '0;
  endtask

  task automatic m_emit(input logic [7:0] b, input logic s);
    exp_wen  = 1'b1;
    exp_data = {b, 1'b1, s};
  endtask

  task automatic m_drop_inc();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic m_start(input logic [7:0] b, input logic f);
    if (f) begin
      m_adm = 1'b0;
      m_drop_inc();
    end else begin
      m_adm = 1'b1;
      m_emit(b, b == 8'h47);
    end
  endtask

  task automatic m_byte(input logic [7:0] b, input logic v, input logic f);
    bit at0;
    bit sync;
    exp_wen = 1'b0;
    if (!v) return;
    sync = (b == 8'h47);
    if (m_st == 0) begin
      if (sync) begin
        m_pos = 1 % PKT;
        m_good = 1;
        if (m_good >= LOCKN) begin
          m_st = 2; m_miss = 0; m_start(b, f);
        end else begin
          m_st = 1;
        end
      end
      return;
    end
    at0 = (m_pos == 0);
    m_pos = (m_pos + 1) % PKT;
    if (m_st == 1) begin
      if (at0 && sync) begin
        m_good++;
        if (m_good >= LOCKN) begin
          m_st = 2; m_miss = 0; m_start(b, f);
        end
      end else if (at0) begin
        m_st = 0; m_pos = 0; m_good = 0;
      end
    end else begin
      if (at0) begin
        m_miss = sync ? 0 : m_miss + 1;
        if (m_miss >= LOSSN) begin
          m_st = 0; m_pos = 0; m_miss = 0; m_good = 0; m_adm = 1'b0;
        end else begin
          m_start(b, f);
        end
      end else if (m_adm) begin
        if (f) begin
          m_adm = 1'b0;
          m_drop_inc();
        end else begin
          m_emit(b, 1'b0);
        end
      end
    end
  endtask

  // One wclk cycle: drive, predict, then compare 1 ns after the edge.
  task automatic step(input logic [7:0] b, input logic v, input logic f);
    din = b; din_valid = v; fifo_full = f;
    m_byte(b, v, f);
    @(posedge wclk);
    #1;
    check("w_en", 32'(w_en), 32'(exp_wen));
    check("data_out", 32'(data_out), 32'(exp_data));
    check("locked", 32'(locked), 32'(m_st == 2));
`ifdef TS_ALIGN_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    if (w_en === 1'b1) words.push_back(data_out);
  endtask

  function automatic logic [7:0] pay();
    logic [7:0] r;
    r = 8'($urandom_range(0, 255));
    if (r == 8'h47) r = 8'h48;
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic f, input bit gap);
    if (gap) begin
      for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) step(pay(), 1'b0, 1'b0);
    end
    step(b, 1'b1, f);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int full_at, input bit gap);
    for (int i = 0; i < PKT; i++) send_byte((i == 0) ? hdr : pay(), i == full_at, gap);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    m_reset();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nsync;
    int         nmis;
    logic [9:0] first;

    m_reset();
    rst = 1'b1;
    repeat (3) @(posedge wclk);
    #1;
    check("rst_w_en", 32'(w_en), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
`ifdef TS_ALIGN_DROP_CNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
    rst = 1'b0;

    // Four clean packets: lock on the third sync, packets 3 and 4 written.
    words.delete();
    repeat (4) send_pkt(8'h47, -1, 1'b0);
    nsync = 0;
    foreach (words[i]) if (words[i][0]) nsync++;
    check("clean_words", 32'(words.size()), 32'd376);
    check("clean_sync_words", 32'(nsync), 32'd2);
    check("clean_locked", 32'(locked), 32'h1);

    // Single bad header is flywheeled through with sync=0.
    words.delete();
    send_pkt(8'h00, -1, 1'b0);
    first = (words.size() > 0) ? words[0] : 10'h3FF;
    check("bad_hdr_words", 32'(words.size()), 32'd188);
    check("bad_hdr_first", 32'(first), 32'({8'h00, 1'b1, 1'b0}));
    check("bad_hdr_locked", 32'(locked), 32'h1);
    send_pkt(8'h47, -1, 1'b0);

    // Three consecutive bad headers drop lock; third packet not written.
    words.delete();
    send_pkt(8'h00, -1, 1'b0);
    send_pkt(8'h11, -1, 1'b0);
    check("two_bad_words", 32'(words.size()), 32'd376);
    words.delete();
    send_pkt(8'h00, -1, 1'b0);
    check("third_bad_words", 32'(words.size()), 32'd0);
    check("third_bad_locked", 32'(locked), 32'h0);

    // Relock: only the packet of the third sync is written.
    words.delete();
    repeat (3) send_pkt(8'h47, -1, 1'b0);
    check("relock_words", 32'(words.size()), 32'd188);
    check("relock_locked", 32'(locked), 32'h1);

    // FIFO full at packet start suppresses the whole packet.
    words.delete();
    send_pkt(8'h47, 0, 1'b0);
    check("full_start_words", 32'(words.size()), 32'd0);
`ifdef TS_ALIGN_DROP_CNT_EN
    check("full_start_drop", 32'(drop_cnt), 32'd1);
`endif
    words.delete();
    send_pkt(8'h47, -1, 1'b0);
    check("after_full_words", 32'(words.size()), 32'd188);

    // FIFO full at pos 100 truncates after 100 words.
    words.delete();
    send_pkt(8'h47, 100, 1'b0);
    check("trunc_words", 32'(words.size()), 32'd100);
`ifdef TS_ALIGN_DROP_CNT_EN
    check("trunc_drop", 32'(drop_cnt), 32'd2);
`endif
    words.delete();
    send_pkt(8'h47, -1, 1'b0);
    check("after_trunc_words", 32'(words.size()), 32'd188);

    // Same byte stream with and without din_valid gaps gives the same words.
    stim.delete();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < PKT; i++) stim.push_back((i == 0) ? 8'h47 : pay());
    end
    pulse_reset();
    words.delete();
    foreach (stim[i]) send_byte(stim[i], 1'b0, 1'b0);
    q1 = words;
    pulse_reset();
    words.delete();
    foreach (stim[i]) send_byte(stim[i], 1'b0, 1'b1);
    nmis = 0;
    foreach (q1[i]) if (i >= words.size() || q1[i] !== words[i]) nmis++;
    check("gapless_words", 32'(q1.size()), 32'd564);
    check("gapped_words", 32'(words.size()), 32'd564);
    check("gap_seq_diff", 32'(nmis), 32'd0);

    // Async reset at pos 50 of a locked packet.
    words.delete();
    for (int i = 0; i <= 50; i++) step((i == 0) ? 8'h47 : pay(), 1'b1, 1'b0);
    check("pre_rst_words", 32'(words.size()), 32'd51);
    rst = 1'b1;
    m_reset();
    #1;
    check("async_rst_w_en", 32'(w_en), 32'h0);
    check("async_rst_data", 32'(data_out), 32'h0);
    check("async_rst_locked", 32'(locked), 32'h0);
    #1;
    rst = 1'b0;
    words.delete();
    for (int i = 51; i < PKT; i++) send_byte(pay(), 1'b0, 1'b0);
    repeat (3) send_pkt(8'h47, -1, 1'b0);
    first = (words.size() > 0) ? words[0] : 10'h3FF;
    check("post_rst_words", 32'(words.size()), 32'd188);
    check("post_rst_first", 32'(first), 32'({8'h47, 1'b1, 1'b1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ts_sync_aligner.md
TS_SYNC_ALIGNER -- requirements
Module: ts_sync_aligner

Interface
REQ-001 SHALL have parameter PKT_LEN, default 188, MPEG-2 TS packet length in bytes.
REQ-002 SHALL have parameter LOCK_COUNT, default 3, consecutive good sync bytes needed to lock (1..15).
REQ-003 SHALL have parameter LOSS_COUNT, default 3, consecutive missed sync bytes needed to drop lock (1..15).
REQ-004 SHALL have port wclk  input  1  write-domain clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port din  input  8  incoming TS byte.
REQ-007 SHALL have port din_valid  input  1  din qualifier, one byte per cycle when high.
REQ-008 SHALL have port fifo_full  input  1  full flag of the downstream async FIFO (wclk domain).
REQ-009 SHALL have port w_en  output  1  FIFO write strobe, registered.
REQ-010 SHALL have port data_out  output  10  FIFO word: [9:2]=byte, [1]=valid, [0]=sync, registered.
REQ-011 SHALL have port locked  output  1  high while state is LOCKED.
REQ-012 SHALL have port drop_cnt  output  16  dropped-packet counter, present only with TS_ALIGN_DROP_CNT_EN.

Function
REQ-013 SHALL implement states HUNT, VERIFY, LOCKED; byte position counter pos (0..PKT_LEN-1) advances only on din_valid.
REQ-014 HUNT: valid byte 0x47 -> VERIFY, pos=1, good=1; other bytes ignored.
REQ-015 VERIFY: valid byte at pos wrap (pos==PKT_LEN-1 -> 0) SHALL be checked; 0x47 increments good, else -> HUNT with good=0.
REQ-016 VERIFY: when good reaches LOCK_COUNT on a 0x47 byte, SHALL enter LOCKED; that byte SHALL be the first emitted (packet start).
REQ-017 LOCKED: packet-start byte 0x47 clears miss; non-0x47 increments miss, byte emitted with sync=0, flywheel timing kept.
REQ-018 LOCKED: miss reaching LOSS_COUNT SHALL go to HUNT; the offending byte and the rest of that packet SHALL NOT be emitted.
REQ-019 LOCKED: if LOCK_COUNT==1, the first 0x47 in HUNT SHALL go directly to LOCKED and be emitted.
REQ-020 Emission: each valid byte in LOCKED of an admitted packet SHALL produce w_en=1 one cycle later with data_out={byte,1'b1,sync}; sync=1 only for 0x47 at pos 0.
REQ-021 Admission: packet admitted iff fifo_full=0 in the cycle its pos-0 byte arrives; else all PKT_LEN bytes suppressed.
REQ-022 fifo_full=1 while a byte of an admitted packet arrives: that byte and the remainder of the packet SHALL be suppressed (truncation); next packet re-evaluated per REQ-021.
REQ-023 w_en SHALL never be high in a cycle following a byte sampled with fifo_full=1.
REQ-024 data_out SHALL hold its last value when w_en=0; din_valid=0 gaps SHALL not advance pos or state.
REQ-025 Latency din -> data_out/w_en SHALL be exactly 1 wclk cycle.

Reset
REQ-026 rst SHALL asynchronously force state=HUNT, pos=0, good=0, miss=0, w_en=0, data_out=0, locked=0, drop_cnt=0.
REQ-027 rst asserted mid-packet SHALL discard the partial packet; no w_en until relock after release.

Configuration
REQ-028 Macro TS_ALIGN_DROP_CNT_EN defined: drop_cnt increments by 1 per suppressed or truncated packet in LOCKED, saturating at 16'hFFFF.
REQ-029 Macro TS_ALIGN_DROP_CNT_EN undefined: drop_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, then 4 clean 188-byte packets (0x47 + 187 bytes), LOCK_COUNT=3 -> locked after 3rd sync, packet 3 and 4 emitted, 376 w_en pulses, sync=1 on 2 words.
REQ-031 Locked stream, one packet with header 0x00 -> word emitted as {0x00,1,0}, locked stays 1; 3 consecutive bad headers -> locked=0, no w_en after third bad header.
REQ-032 fifo_full=1 at a packet-start byte -> 0 w_en for that packet, next packet fully emitted, drop_cnt=1 (macro on).
REQ-033 fifo_full pulse at pos 100 of admitted packet -> exactly 100 words written, rest suppressed, drop_cnt increments by 1.
REQ-034 Random din_valid gaps (50%) on clean stream -> word sequence identical to gapless run, latency 1 cycle per byte.
REQ-035 rst pulse at pos 50 while locked -> outputs 0 immediately, relock after LOCK_COUNT syncs, first emitted word {0x47,1,1}.
